// File: rtl/led_display_pkg.sv
// Shared types and defaults for the LED panel row path (frame RAM -> row fetch -> phy).
package led_display_pkg;

  localparam int unsigned LED_NUM_ROWS = 32;
  localparam int unsigned LED_NUM_COLS = 64;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  localparam int unsigned CH_R = 2;
  localparam int unsigned CH_G = 1;
  localparam int unsigned CH_B = 0;

  typedef logic [2:0][LED_NUM_COLS-1:0] row_bus_t;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDrain,
    StHandoff,
    StDone
  } fetch_state_t;

endpackage

// File: rtl/led_rd_tag_pipe.sv
// Shift register that carries {valid, is_bot, col} alongside each outstanding frame RAM read.
module led_rd_tag_pipe #(
  parameter int unsigned Latency = 2,
  parameter int unsigned ColW    = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            push_bot,
  input  logic [ColW-1:0] push_col,
  output logic            pop_valid,
  output logic            pop_bot,
  output logic [ColW-1:0] pop_col,
  output logic            pending
);

  typedef struct packed {
    logic            valid;
    logic            is_bot;
    logic [ColW-1:0] col;
  } tag_t;

  localparam logic [Latency-1:0] LastMask = Latency'(1) << (Latency - 1);

  tag_t [Latency-1:0] stage_q;
  logic [Latency-1:0] valid_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= '{valid: push, is_bot: push_bot, col: push_col};
      for (int i = 1; i < Latency; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < Latency; i++) begin
      valid_vec[i] = stage_q[i].valid;
    end
  end

  assign pop_valid = stage_q[Latency-1].valid;
  assign pop_bot   = stage_q[Latency-1].is_bot;
  assign pop_col   = stage_q[Latency-1].col;
  // Reads still in flight beyond the one emerging this cycle.
  assign pending   = |(valid_vec & ~LastMask);

endmodule

// File: rtl/led_row_fetch.sv
// Fetches a top/bottom row pair from frame RAM, slices one bit-plane per channel, hands it to the
// phy. Define LED_ROW_FETCH_TIMEOUT_EN to add the sticky phy-ready watchdog (error_out).
module led_row_fetch
  import led_display_pkg::*;
#(
  parameter int unsigned NUM_ROWS       = LED_NUM_ROWS,
  parameter int unsigned NUM_COLS       = LED_NUM_COLS,
  parameter int unsigned RAM_ADDR_W     = 16,
  parameter int unsigned RAM_LATENCY    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                           clk_in,
  input  logic                           reset_in,
  input  logic                           start_in,
  input  logic [3:0]                     row_in,
  input  logic [2:0]                     plane_in,
  output logic                           busy_out,
  output logic                           done_out,
  output logic                           ram_enable_out,
  output logic [RAM_ADDR_W-1:0]          ram_addr_out,
  input  logic [23:0]                    ram_data_in,
  output logic [2:0][NUM_COLS-1:0]       col_top_out,
  output logic [2:0][NUM_COLS-1:0]       col_bot_out,
  output logic                           phy_enable_out,
  input  logic                           phy_ready_in,
  output logic                           error_out
);

  // NUM_COLS must be a power of two: the fetch counter splits into {is_bot, col}.
  localparam int unsigned ColW = $clog2(NUM_COLS);
  localparam int unsigned CntW = ColW + 1;

  fetch_state_t             state_q;
  logic [CntW-1:0]          cnt_q;
  logic [3:0]               row_q;
  logic [2:0]               plane_q;
  logic [2:0][NUM_COLS-1:0] col_top_q;
  logic [2:0][NUM_COLS-1:0] col_bot_q;

  logic                  issue_bot;
  logic [ColW-1:0]       issue_col;
  logic [RAM_ADDR_W-1:0] issue_row;
  logic [RAM_ADDR_W-1:0] issue_addr;
  logic                  tag_valid;
  logic                  tag_bot;
  logic                  tag_pending;
  logic [ColW-1:0]       tag_col;
  logic                  timeout_hit;
  rgb24_t                pixel;

  assign issue_bot  = cnt_q[ColW];
  assign issue_col  = cnt_q[ColW-1:0];
  assign issue_row  = RAM_ADDR_W'(row_q) + (issue_bot ? RAM_ADDR_W'(NUM_ROWS / 2) : '0);
  assign issue_addr = issue_row * RAM_ADDR_W'(NUM_COLS) + RAM_ADDR_W'(issue_col);
  assign pixel      = rgb24_t'(ram_data_in);

  assign busy_out       = (state_q != StIdle);
  assign done_out       = (state_q == StDone);
  assign ram_enable_out = (state_q == StFetch);
  assign ram_addr_out   = ram_enable_out ? issue_addr : '0;
  assign phy_enable_out = (state_q == StHandoff) && phy_ready_in;
  assign col_top_out    = col_top_q;
  assign col_bot_out    = col_bot_q;

  led_rd_tag_pipe #(
    .Latency (RAM_LATENCY),
    .ColW    (ColW)
  ) u_tag_pipe (
    .clk       (clk_in),
    .reset     (reset_in),
    .push      (ram_enable_out),
    .push_bot  (issue_bot),
    .push_col  (issue_col),
    .pop_valid (tag_valid),
    .pop_bot   (tag_bot),
    .pop_col   (tag_col),
    .pending   (tag_pending)
  );

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      row_q     <= '0;
      plane_q   <= '0;
      col_top_q <= '0;
      col_bot_q <= '0;
    end else begin
      if (tag_valid) begin
        if (tag_bot) begin
          col_bot_q[CH_R][tag_col] <= pixel.r[plane_q];
          col_bot_q[CH_G][tag_col] <= pixel.g[plane_q];
          col_bot_q[CH_B][tag_col] <= pixel.b[plane_q];
        end else begin
          col_top_q[CH_R][tag_col] <= pixel.r[plane_q];
          col_top_q[CH_G][tag_col] <= pixel.g[plane_q];
          col_top_q[CH_B][tag_col] <= pixel.b[plane_q];
        end
      end

      unique case (state_q)
        StIdle: begin
          if (start_in) begin
            row_q   <= row_in;
            plane_q <= plane_in;
            cnt_q   <= '0;
            state_q <= StFetch;
          end
        end
        StFetch: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(2 * NUM_COLS - 1)) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (!tag_pending) begin
            state_q <= StHandoff;
          end
        end
        StHandoff: begin
          if (phy_ready_in || timeout_hit) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef LED_ROW_FETCH_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

  logic [ToW-1:0] to_cnt_q;
  logic           error_q;

  assign timeout_hit = (state_q == StHandoff) && !phy_ready_in &&
                       (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      to_cnt_q <= '0;
      error_q  <= 1'b0;
    end else if (state_q == StHandoff) begin
      to_cnt_q <= to_cnt_q + 1'b1;
      if (timeout_hit) begin
        error_q <= 1'b1;
      end
    end else begin
      to_cnt_q <= '0;
    end
  end

  assign error_out = error_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
  assign error_out      = 1'b0;
`endif

endmodule

// File: tb/tb_led_row_fetch.sv
// Bench for led_row_fetch: vector table of row fetches against a frame RAM model, plus reset-abort
// and (with LED_ROW_FETCH_TIMEOUT_EN) watchdog sequences.
module tb_led_row_fetch;
  import led_display_pkg::*;

  localparam int unsigned NR  = 32;
  localparam int unsigned NC  = 64;
  localparam int unsigned AW  = 16;
  localparam int unsigned LAT = 2;
  localparam int unsigned TO  = 100;
  localparam int HANDOFF_N = 2 * NC + LAT + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    row = '0;
  logic [2:0]    plane = '0;
  logic          busy;
  logic          done;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [23:0]   ram_data;
  row_bus_t      col_top;
  row_bus_t      col_bot;
  logic          phy_en;
  logic          phy_ready = 1'b0;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;
  int mode = 0;

  logic [AW-1:0] addr_q[$];
  row_bus_t      top_q[$];
  row_bus_t      bot_q[$];

  led_row_fetch #(
    .NUM_ROWS       (NR),
    .NUM_COLS       (NC),
    .RAM_ADDR_W     (AW),
    .RAM_LATENCY    (LAT),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_in         (clk),
    .reset_in       (reset),
    .start_in       (start),
    .row_in         (row),
    .plane_in       (plane),
    .busy_out       (busy),
    .done_out       (done),
    .ram_enable_out (ram_en),
    .ram_addr_out   (ram_addr),
    .ram_data_in    (ram_data),
    .col_top_out    (col_top),
    .col_bot_out    (col_bot),
    .phy_enable_out (phy_en),
    .phy_ready_in   (phy_ready),
    .error_out      (err)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] word_at(input int m, input int a);
    logic [31:0] x;
    case (m)
      0: return 24'(a);
      1: return 24'hFFFFFF;
      default: begin
        x = 32'(a) * 32'h9E3779B1;
        return x[31:8] ^ x[23:0];
      end
    endcase
  endfunction

  // Frame RAM with LAT cycles of read latency; junk when not enabled.
  logic [23:0] ram_pipe [LAT];
  always @(posedge clk) begin
    ram_pipe[0] <= ram_en ? word_at(mode, int'(ram_addr)) : 24'hA5C3E1;
    for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign ram_data = ram_pipe[LAT-1];

  function automatic row_bus_t model_bus(input int m, input int base, input int pl);
    row_bus_t b;
    rgb24_t   px;
    for (int k = 0; k < NC; k++) begin
      px = word_at(m, base + k);
      b[CH_R][k] = px.r[pl];
      b[CH_G][k] = px.g[pl];
      b[CH_B][k] = px.b[pl];
    end
    return b;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         mode;
    logic [3:0] row;
    logic [2:0] plane;
    int         delay;
    row_bus_t   top;
    row_bus_t   bot;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int m, input int r, input int p, input int d,
                              input row_bus_t t, input row_bus_t b);
    vec_t v;
    v.mode = m; v.row = 4'(r); v.plane = 3'(p); v.delay = d; v.top = t; v.bot = b;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int       n_en_exp;
    int       n_en;
    int       n_done;
    int       en_cnt;
    int       busy_cnt;
    int       addr_seen;
    int       addr_bad;
    bit       stable_ok;
    bit       err_seen;
    logic [AW-1:0] exp_a;
    row_bus_t et;
    row_bus_t eb;
    n_en_exp = HANDOFF_N + v.delay;
    n_en = -1; n_done = -1; en_cnt = 0; busy_cnt = 0; addr_seen = 0; addr_bad = 0;
    stable_ok = 1'b1; err_seen = 1'b0;
    addr_q.delete(); top_q.delete(); bot_q.delete();
    for (int k = 0; k < int'(NC); k++) addr_q.push_back(AW'(int'(v.row) * NC + k));
    for (int k = 0; k < int'(NC); k++) addr_q.push_back(AW'((int'(v.row) + NR / 2) * NC + k));
    top_q.push_back(v.top);
    bot_q.push_back(v.bot);
    mode = v.mode;

    @(posedge clk); #1;
    start = 1'b1; row = v.row; plane = v.plane; phy_ready = (v.delay == 0);
    for (int n = 1; n <= n_en_exp + 3; n++) begin
      @(posedge clk); #1;
      // Stray starts while busy (mid-fetch and in DONE) must be ignored.
      start = (n == 5) || (n == n_en_exp + 1);
      row = v.row ^ 4'd1;
      phy_ready = (v.delay == 0) || (n >= n_en_exp);
      @(negedge clk);
      if (busy) busy_cnt++;
      if (err) err_seen = 1'b1;
      if (ram_en) begin
        addr_seen++;
        if (addr_q.size() == 0) addr_bad++;
        else begin
          exp_a = addr_q.pop_front();
          if (ram_addr !== exp_a) addr_bad++;
        end
      end
      if (phy_en) begin
        en_cnt++;
        if (n_en < 0) n_en = n;
        if (top_q.size() > 0) begin
          et = top_q.pop_front();
          eb = bot_q.pop_front();
          check({tag, "/col_top"}, col_top, et);
          check({tag, "/col_bot"}, col_bot, eb);
        end
      end
      if (done && n_done < 0) n_done = n;
      if (n >= HANDOFF_N && n <= n_en_exp + 2 && (col_top !== v.top || col_bot !== v.bot))
        stable_ok = 1'b0;
    end
    start = 1'b0;
    check({tag, "/bus_unconsumed"}, top_q.size(), 0);
    check({tag, "/addr_count"}, addr_seen, 2 * NC);
    check({tag, "/addr_bad"}, addr_bad, 0);
    check({tag, "/enable_cycle"}, n_en, n_en_exp);
    check({tag, "/enable_width"}, en_cnt, 1);
    check({tag, "/done_cycle"}, n_done, n_en_exp + 1);
    check({tag, "/busy_cycles"}, busy_cnt, n_en_exp + 1);
    check({tag, "/cols_stable"}, stable_ok, 1);
    check({tag, "/error"}, err_seen, 0);
  endtask

  task automatic run_reset_abort();
    int en_cnt;
    int done_cnt;
    int rd_cnt;
    en_cnt = 0; done_cnt = 0; rd_cnt = 0;
    mode = 0;
    @(posedge clk); #1;
    start = 1'b1; row = 4'd3; plane = 3'd1; phy_ready = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (n == 40) reset = 1'b1;
    end
    @(negedge clk);
    check("abort/busy_mid_fetch", {busy, ram_en}, 2'b11);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort/outputs_zero",
          {busy, done, ram_en, ram_addr, phy_en, err, col_top, col_bot}, '0);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (phy_en) en_cnt++;
      if (done) done_cnt++;
      if (ram_en) rd_cnt++;
    end
    check("abort/no_enable", en_cnt, 0);
    check("abort/no_done", done_cnt, 0);
    check("abort/no_reads", rd_cnt, 0);
    @(posedge clk); #1;
    start = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("start_with_reset/busy", busy, 0);
  endtask

`ifdef LED_ROW_FETCH_TIMEOUT_EN
  task automatic run_timeout();
    int n_err;
    int n_done;
    int en_cnt;
    n_err = -1; n_done = -1; en_cnt = 0;
    mode = 1;
    phy_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; row = 4'd2; plane = 3'd0;
    for (int n = 1; n <= HANDOFF_N + int'(TO) + 10; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (err && n_err < 0) n_err = n;
      if (done && n_done < 0) n_done = n;
      if (phy_en) en_cnt++;
    end
    check("timeout/error_cycle", n_err, HANDOFF_N + int'(TO));
    check("timeout/done_cycle", n_done, HANDOFF_N + int'(TO));
    check("timeout/no_enable", en_cnt, 0);
    check("timeout/error_sticky", {err, busy}, 2'b10);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("timeout/error_cleared", err, 0);
  endtask
`endif

  initial begin
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/busy", busy, 0);
    check("reset/outputs", {done, ram_en, ram_addr, phy_en, err}, '0);
    check("reset/cols", {col_top, col_bot}, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;

    vecs.push_back(mk(0, 0, 0, 0, {64'h0, 64'h0, {16{4'hA}}}, {64'h0, 64'h0, {16{4'hA}}}));
    vecs.push_back(mk(0, 0, 2, 0, {64'h0, 64'h0, {8{8'hF0}}}, {64'h0, {64{1'b1}}, {8{8'hF0}}}));
    for (int p = 0; p < 8; p++) vecs.push_back(mk(1, 5, p, 0, '1, '1));
    vecs.push_back(mk(0, 15, 5, 50, {64'h0, 64'h0, 64'hFFFF_FFFF_0000_0000},
                      {64'h0, 64'h0, 64'hFFFF_FFFF_0000_0000}));
    vecs.push_back(mk(2, 9, 4, 3, model_bus(2, 9 * NC, 4), model_bus(2, (9 + NR / 2) * NC, 4)));
    vecs.push_back(mk(2, 0, 7, 0, model_bus(2, 0, 7), model_bus(2, (NR / 2) * NC, 7)));
    vecs.push_back(mk(2, 15, 1, 1, model_bus(2, 15 * NC, 1),
                      model_bus(2, (15 + NR / 2) * NC, 1)));

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    run_reset_abort();
    run_vec(vecs[0], "after_reset");
`ifdef LED_ROW_FETCH_TIMEOUT_EN
    run_timeout();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no summary, required summary");
    $fatal(1, "watchdog expired");
  end

endmodule
